// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: FS opcodes, FSM states,
// settle-counter width and a helper that identifies HI/LO-writing operations.
package alu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FS_W     = 5;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [FS_W-1:0] FS_PASS_S = 5'h00;
    localparam logic [FS_W-1:0] FS_PASS_T = 5'h01;
    localparam logic [FS_W-1:0] FS_ADD    = 5'h02;
    localparam logic [FS_W-1:0] FS_SUB    = 5'h03;
    localparam logic [FS_W-1:0] FS_AND    = 5'h04;
    localparam logic [FS_W-1:0] FS_OR     = 5'h05;
    localparam logic [FS_W-1:0] FS_XOR    = 5'h06;
    localparam logic [FS_W-1:0] FS_MUL    = 5'h1E;
    localparam logic [FS_W-1:0] FS_DIV    = 5'h1F;

    // Flags reported for a trapped divide-by-zero: only V set, ordered {C,V,N,Z}.
    localparam logic [3:0] DIV0_FLAGS = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issue_state_e;

    // MUL and DIV are the only operations whose 64-bit result lands in HI/LO.
    function automatic logic writes_hilo(input logic [FS_W-1:0] fs);
        return (fs == FS_MUL) || (fs == FS_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_hilo_regs.sv
// Architectural HI/LO register pair written by MUL/DIV results.
// Cleared asynchronously by the active-low reset.
module hilo_regs
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [DATA_W-1:0] hi_d_i,
    input  logic [DATA_W-1:0] lo_d_i,
    output logic [DATA_W-1:0] hi_q_o,
    output logic [DATA_W-1:0] lo_q_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // Load both halves together so HI and LO always belong to the same result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we_i) begin
            hi_q <= hi_d_i;
            lo_q <= lo_d_i;
        end
    end

    assign hi_q_o = hi_q;
    assign lo_q_o = lo_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential initiator for the 32-bit ALU: accepts one command, holds the ALU
// inputs for a settle window, captures the result and returns it over a
// valid/ready response port. MUL/DIV results also update HI/LO.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          DIV0_TRAP     = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FS_W-1:0]   cmd_fs,
    input  logic [DATA_W-1:0] cmd_s,
    input  logic [DATA_W-1:0] cmd_t,
    output logic [DATA_W-1:0] alu_s,
    output logic [DATA_W-1:0] alu_t,
    output logic [FS_W-1:0]   alu_fs,
    input  logic [DATA_W-1:0] alu_y_hi,
    input  logic [DATA_W-1:0] alu_y_lo,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [3:0]        rsp_flags,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic              div0_err
);

    // Counter preload: capture happens when the counter has run down to zero,
    // so a window of N cycles starts at N-1.
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    issue_state_e         state_q;
    logic [SETTLE_W-1:0]  cnt_q;
    logic                 cmd_ready_q;
    logic [DATA_W-1:0]    alu_s_q;
    logic [DATA_W-1:0]    alu_t_q;
    logic [FS_W-1:0]      alu_fs_q;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_y_q;
    logic [3:0]           rsp_flags_q;
    logic                 div0_err_q;

    logic accept;
    logic capture;
    logic div0_trap;
    logic hilo_we;

    assign accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign capture   = (state_q == ST_ISSUE) && (cnt_q == '0);
    assign div0_trap = DIV0_TRAP && (alu_fs_q == FS_DIV) && (alu_t_q == '0);
    assign hilo_we   = capture && writes_hilo(alu_fs_q) && !div0_trap;

    // Issue FSM; every externally visible control and data output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            alu_s_q     <= '0;
            alu_t_q     <= '0;
            alu_fs_q    <= FS_PASS_S;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            div0_err_q  <= 1'b0;
        end else begin
            div0_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_s_q     <= cmd_s;
                        alu_t_q     <= cmd_t;
                        alu_fs_q    <= cmd_fs;
                        cnt_q       <= SETTLE_LOAD;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_ISSUE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (capture) begin
                        rsp_valid_q <= 1'b1;
                        div0_err_q  <= div0_trap;
                        if (div0_trap) begin
                            rsp_y_q     <= '0;
                            rsp_flags_q <= DIV0_FLAGS;
                        end else begin
                            rsp_y_q     <= alu_y_lo;
                            rsp_flags_q <= {alu_c, alu_v, alu_n, alu_z};
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    hilo_regs u_hilo (
        .clk    (clk),
        .rst_n  (reset_n),
        .we_i   (hilo_we),
        .hi_d_i (alu_y_hi),
        .lo_d_i (alu_y_lo),
        .hi_q_o (hi_q),
        .lo_q_o (lo_q)
    );

    assign cmd_ready = cmd_ready_q;
    assign alu_s     = alu_s_q;
    assign alu_t     = alu_t_q;
    assign alu_fs    = alu_fs_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign div0_err  = div0_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl. A behavioural ALU stands in for ALU_32
// on the alu_* ports; expected responses are queued at command acceptance and
// checked by an independent monitor. A second instance covers a 4-cycle settle window.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
    } alu_out_t;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  flags;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          capCyc;
    } exp_t;

    localparam int SETTLE = 1;

    logic clk;
    logic reset_n;
    int   cyc = 0;

    // Main instance signals
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, div0_err;
    logic [4:0]  cmd_fs, alu_fs;
    logic [31:0] cmd_s, cmd_t, alu_s, alu_t, alu_y_hi, alu_y_lo, rsp_y, hi_q, lo_q;
    logic        alu_c, alu_v, alu_n, alu_z;
    logic [3:0]  rsp_flags;
    alu_out_t    aluOut;

    // Settle-4 instance signals
    logic        c4_valid, c4_ready, c4_rsp_valid, c4_rsp_ready, c4_div0;
    logic [4:0]  c4_fs, c4_alu_fs;
    logic [31:0] c4_s, c4_t, c4_alu_s, c4_alu_t, c4_y_lo, c4_rsp_y, c4_hi, c4_lo;
    logic [3:0]  c4_flags;
    alu_out_t    alu4Out;
    logic        inject4;
    logic [31:0] injVal4;

    // Scoreboard state
    exp_t        expQ[$];
    exp_t        cur;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    int          nCompares = 0;
    int          nMiscompares = 0;
    bit          inRsp = 0;
    int          rspLen = 0;
    int          lastRspLen = 0;
    int          lastHs = 0;
    logic [31:0] lastRspY = '0;
    int          div0Pulses = 0;
    int          holdCount = 0;
    bit          randReady = 0;

    // Behavioural ALU: signed MUL/DIV, flags {C,V,N,Z} from the low word.
    function automatic alu_out_t aluRef(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
        alu_out_t          r;
        logic [32:0]       wide;
        logic signed [63:0] prod;
        r = '0;
        case (fs)
            FS_PASS_S: r.lo = s;
            FS_PASS_T: r.lo = t;
            FS_ADD: begin
                wide = {1'b0, s} + {1'b0, t};
                r.lo = wide[31:0];
                r.c  = wide[32];
                r.v  = (s[31] == t[31]) && (r.lo[31] != s[31]);
            end
            FS_SUB: begin
                wide = {1'b0, s} + {1'b0, ~t} + 33'd1;
                r.lo = wide[31:0];
                r.c  = wide[32];
                r.v  = (s[31] != t[31]) && (r.lo[31] != s[31]);
            end
            FS_AND: r.lo = s & t;
            FS_OR:  r.lo = s | t;
            FS_XOR: r.lo = s ^ t;
            FS_MUL: begin
                prod = $signed(s) * $signed(t);
                r.hi = prod[63:32];
                r.lo = prod[31:0];
            end
            FS_DIV: begin
                if (t == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = s;
                end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
                    r.lo = s;
                    r.hi = 32'd0;
                end else begin
                    r.lo = $signed(s) / $signed(t);
                    r.hi = $signed(s) % $signed(t);
                end
            end
            default: r.lo = ~s;
        endcase
        r.n = r.lo[31];
        r.z = (r.lo == 32'd0);
        return r;
    endfunction

    assign aluOut   = aluRef(alu_fs, alu_s, alu_t);
    assign alu_y_hi = aluOut.hi;
    assign alu_y_lo = aluOut.lo;
    assign alu_c    = aluOut.c;
    assign alu_v    = aluOut.v;
    assign alu_n    = aluOut.n;
    assign alu_z    = aluOut.z;

    assign alu4Out  = aluRef(c4_alu_fs, c4_alu_s, c4_alu_t);
    assign c4_y_lo  = inject4 ? injVal4 : alu4Out.lo;

    alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .DIV0_TRAP(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fs(cmd_fs), .cmd_s(cmd_s), .cmd_t(cmd_t),
        .alu_s(alu_s), .alu_t(alu_t), .alu_fs(alu_fs),
        .alu_y_hi(alu_y_hi), .alu_y_lo(alu_y_lo),
        .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .hi_q(hi_q), .lo_q(lo_q), .div0_err(div0_err)
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(4), .DIV0_TRAP(1'b1)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c4_valid), .cmd_ready(c4_ready),
        .cmd_fs(c4_fs), .cmd_s(c4_s), .cmd_t(c4_t),
        .alu_s(c4_alu_s), .alu_t(c4_alu_t), .alu_fs(c4_alu_fs),
        .alu_y_hi(alu4Out.hi), .alu_y_lo(c4_y_lo),
        .alu_c(alu4Out.c), .alu_v(alu4Out.v), .alu_n(alu4Out.n), .alu_z(alu4Out.z),
        .rsp_valid(c4_rsp_valid), .rsp_ready(c4_rsp_ready),
        .rsp_y(c4_rsp_y), .rsp_flags(c4_flags),
        .hi_q(c4_hi), .lo_q(c4_lo), .div0_err(c4_div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time-stamp accepts and responses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompares++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        nCompares++;
        nMiscompares++;
        $display("[TB] FAIL %s: no progress within cycle budget (cycle %0d)", name, cyc);
    endtask

    // Present a command and hold it until the DUT accepts it; returns the accept edge.
    task automatic applyStimulus(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                                 output int acceptCyc);
        int waited;
        waited    = 0;
        acceptCyc = -1;
        cmd_fs    = fs;
        cmd_s     = s;
        cmd_t     = t;
        cmd_valid = 1'b1;
        while (acceptCyc < 0 && waited < 200) begin
            @(negedge clk);
            if (cmd_ready) acceptCyc = cyc + 1;
            @(posedge clk);
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        if (acceptCyc < 0) reportTimeout("cmd_accept");
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || rsp_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) reportTimeout("drain");
        @(posedge clk);
        #1;
    endtask

    // Issue tracker: predicts the response of each accepted command.
    initial begin
        alu_out_t r;
        exp_t     e;
        forever begin
            @(negedge clk);
            if (reset_n && cmd_valid && cmd_ready) begin
                r = aluRef(cmd_fs, cmd_s, cmd_t);
                e.capCyc = cyc + 1 + SETTLE;
                if (cmd_fs == FS_DIV && cmd_t == 32'd0) begin
                    e.y     = 32'd0;
                    e.flags = 4'b0100;
                    e.div0  = 1'b1;
                end else begin
                    e.y     = r.lo;
                    e.flags = {r.c, r.v, r.n, r.z};
                    e.div0  = 1'b0;
                    if (cmd_fs == FS_MUL || cmd_fs == FS_DIV) begin
                        modelHi = r.hi;
                        modelLo = r.lo;
                    end
                end
                e.hi = modelHi;
                e.lo = modelLo;
                expQ.push_back(e);
            end
        end
    end

    // Response monitor: pops on the first valid cycle, then checks stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                inRsp = 1'b0;
            end else begin
                if (div0_err) div0Pulses++;
                if (rsp_valid) begin
                    if (!inRsp) begin
                        if (expQ.size() == 0) begin
                            reportTimeout("rsp_unexpected");
                        end else begin
                            cur = expQ.pop_front();
                            checkOutput("rsp_latency", 64'(cyc), 64'(cur.capCyc));
                        end
                        inRsp  = 1'b1;
                        rspLen = 0;
                        checkOutput("div0_err_first", div0_err, cur.div0);
                        checkOutput("hi_q", hi_q, cur.hi);
                        checkOutput("lo_q", lo_q, cur.lo);
                    end else begin
                        checkOutput("div0_err_hold", div0_err, 1'b0);
                    end
                    rspLen++;
                    checkOutput("rsp_y", rsp_y, cur.y);
                    checkOutput("rsp_flags", rsp_flags, cur.flags);
                    checkOutput("cmd_ready_in_resp", cmd_ready, 1'b0);
                    if (rsp_ready) begin
                        inRsp      = 1'b0;
                        lastHs     = cyc + 1;
                        lastRspLen = rspLen;
                        lastRspY   = rsp_y;
                    end
                end else if (inRsp) begin
                    checkOutput("rsp_valid_dropped", rsp_valid, 1'b1);
                    inRsp = 1'b0;
                end else begin
                    checkOutput("div0_err_idle", div0_err, 1'b0);
                end
            end
        end
    end

    // Response consumer: forced backpressure, random readiness, or always ready.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (holdCount > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) holdCount--;
            end else if (randReady) begin
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          accA, accB, pulses0, idleGap;
        logic [4:0]  fsTab[10];
        logic [4:0]  fs;
        logic [31:0] s, t;

        fsTab = '{FS_PASS_S, FS_PASS_T, FS_ADD, FS_SUB, FS_AND, FS_OR, FS_XOR, FS_MUL, FS_DIV, 5'h0A};
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_fs = '0; cmd_s = '0; cmd_t = '0;
        c4_valid = 1'b0; c4_fs = '0; c4_s = '0; c4_t = '0; c4_rsp_ready = 1'b0;
        inject4 = 1'b0; injVal4 = '0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready", cmd_ready, 1'b0);
        checkOutput("rst_alu_s", alu_s, 32'd0);
        checkOutput("rst_alu_t", alu_t, 32'd0);
        checkOutput("rst_alu_fs", alu_fs, 5'h00);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_rsp_y", rsp_y, 32'd0);
        checkOutput("rst_rsp_flags", rsp_flags, 4'd0);
        checkOutput("rst_hi", hi_q, 32'd0);
        checkOutput("rst_lo", lo_q, 32'd0);
        checkOutput("rst_div0", div0_err, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", cmd_ready, 1'b1);

        // ADD, then MUL, then DIV and a trapped DIV by zero
        applyStimulus(FS_ADD, 32'd5, 32'd7, accA);
        waitIdle();
        checkOutput("add_result", lastRspY, 32'd12);
        applyStimulus(FS_MUL, 32'hFFFF_FFFF, 32'd2, accA);
        waitIdle();
        checkOutput("mul_hi", hi_q, 32'hFFFF_FFFF);
        checkOutput("mul_lo", lo_q, 32'hFFFF_FFFE);
        applyStimulus(FS_DIV, 32'd17, 32'd5, accA);
        waitIdle();
        checkOutput("div_hi", hi_q, 32'd2);
        checkOutput("div_lo", lo_q, 32'd3);
        pulses0 = div0Pulses;
        applyStimulus(FS_DIV, 32'd7, 32'd0, accA);
        waitIdle();
        checkOutput("div0_pulse_count", 64'(div0Pulses - pulses0), 64'd1);
        checkOutput("div0_hi_kept", hi_q, 32'd2);
        checkOutput("div0_lo_kept", lo_q, 32'd3);

        // Backpressure with a second command waiting
        holdCount = 5;
        applyStimulus(FS_ADD, 32'd10, 32'd20, accA);
        applyStimulus(FS_SUB, 32'd3, 32'd9, accB);
        checkOutput("bp_rsp_len", 64'(lastRspLen), 64'd6);
        checkOutput("bp_second_accept", 64'(accB), 64'(lastHs + 1));
        waitIdle();

        // Randomized traffic with random consumer readiness
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fs = fsTab[$urandom_range(0, 9)];
            s  = $urandom;
            t  = $urandom;
            if (fs == FS_DIV && $urandom_range(0, 3) == 0) t = 32'd0;
            if ($urandom_range(0, 3) == 0) t = t & 32'h0000_00FF;
            applyStimulus(fs, s, t, accA);
            idleGap = $urandom_range(0, 2);
            repeat (idleGap) begin @(posedge clk); #1; end
        end
        waitIdle();
        randReady = 1'b0;

        // Reset during ISSUE of a MUL
        applyStimulus(FS_DIV, 32'd17, 32'd5, accA);
        waitIdle();
        applyStimulus(FS_MUL, 32'hFFFF_FFFF, 32'd2, accA);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_cmd_ready", cmd_ready, 1'b0);
        checkOutput("mid_rst_alu_s", alu_s, 32'd0);
        checkOutput("mid_rst_alu_fs", alu_fs, 5'h00);
        checkOutput("mid_rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("mid_rst_hi", hi_q, 32'd0);
        checkOutput("mid_rst_lo", lo_q, 32'd0);
        expQ.delete();
        modelHi = '0;
        modelLo = '0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready_after_mid_reset", cmd_ready, 1'b1);
        applyStimulus(FS_ADD, 32'd1, 32'd1, accA);
        waitIdle();
        checkOutput("post_reset_add", lastRspY, 32'd2);

        // Settle window of 4: the value present at accept+4 is the one captured
        c4_fs = FS_ADD; c4_s = 32'd100; c4_t = 32'd23; c4_valid = 1'b1;
        @(negedge clk);
        checkOutput("s4_cmd_ready", c4_ready, 1'b1);
        @(posedge clk); #1;
        c4_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("s4_no_early_valid", c4_rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        inject4 = 1'b1;
        injVal4 = 32'hA5A5_0003;
        @(negedge clk);
        checkOutput("s4_no_valid_edge3", c4_rsp_valid, 1'b0);
        @(posedge clk); #1;
        injVal4 = 32'h5A5A_0004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("s4_rsp_valid", c4_rsp_valid, 1'b1);
            checkOutput("s4_rsp_y", c4_rsp_y, 32'hA5A5_0003);
            checkOutput("s4_rsp_flags", c4_flags, 4'b0000);
            checkOutput("s4_alu_s_held", c4_alu_s, 32'd100);
            checkOutput("s4_div0", c4_div0, 1'b0);
            @(posedge clk); #1;
        end
        c4_rsp_ready = 1'b1;
        @(posedge clk); #1;
        c4_rsp_ready = 1'b0;
        inject4 = 1'b0;
        @(negedge clk);
        checkOutput("s4_rsp_dropped", c4_rsp_valid, 1'b0);
        checkOutput("s4_ready_again", c4_ready, 1'b1);
        checkOutput("s4_hilo_untouched", {c4_hi, c4_lo}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
        $finish;
    end

endmodule
